// File: rtl/axis_io_route_stage_if.sv
// AXI4-Stream bundle used on both sides of axis_io_route_stage.
//   tvalid/tready : handshake
//   tdata/tkeep   : payload and byte enables (tkeep is DATA_BITS/8 wide)
//   tlast         : end of packet
//   tdest         : switch destination (only meaningful on the master side of the stage)
// master modport drives the beat, slave modport drives tready.
interface axis_io_route_stage_if #(
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned DEST_BITS = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic [DEST_BITS-1:0]   tdest;

  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    output tdest,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tdest,
    output tready
  );
endinterface

// File: rtl/axis_io_route_stage.sv
// Per-stream routing stage in front of one slave port of the vFPGA data switch.
// The io_ctrl byte is sampled on the head beat of every packet. Enabled packets with a legal
// destination are tagged with that tdest on every beat; all others are accepted and discarded.
// Output goes through a 2-entry skid buffer (output register + skid register) for full throughput.
// Ports:
//   aclk, aresetn  : clock, synchronous active-low reset
//   io_ctrl        : [7] route enable, [DEST_BITS-1:0] destination, other bits ignored
//   s_axis         : input stream (slave modport; its tdest is ignored)
//   m_axis         : output stream (master modport) carrying the routed tdest
//   stat_pkt_cnt   : forwarded packets, wraps at 2^16
//   stat_drop_cnt  : dropped packets, wraps at 2^16
//   busy           : mid-packet or skid buffer non-empty
module axis_io_route_stage #(
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned DEST_BITS = 2,
  parameter int unsigned N_DEST    = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [7:0]            io_ctrl,
  axis_io_route_stage_if.slave  s_axis,
  axis_io_route_stage_if.master m_axis,
  output logic [15:0]           stat_pkt_cnt,
  output logic [15:0]           stat_drop_cnt,
  output logic                  busy
);

  localparam int unsigned KeepBits = DATA_BITS / 8;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [KeepBits-1:0]  keep;
    logic                 last;
    logic [DEST_BITS-1:0] dest;
  } beat_t;

  typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

  state_e               state_q, state_d;
  logic [DEST_BITS-1:0] dest_q, dest_d;
  beat_t                out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  beat_t                skid_q, skid_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic                 s_ready;
  logic                 accept;
  logic [DEST_BITS-1:0] head_dest;
  logic                 head_ok;
  logic                 push;
  logic [DEST_BITS-1:0] push_dest;
  beat_t                push_beat;
  logic                 pop;

  // Only enable and destination bits of io_ctrl matter; s_axis.tdest is never routed.
  logic unused_inputs;
  assign unused_inputs = ^{io_ctrl, s_axis.tdest};

  assign head_dest = io_ctrl[DEST_BITS-1:0];
  assign head_ok   = io_ctrl[7] && (32'(head_dest) < N_DEST);

  // Ready depends only on registered state, never on m_axis.tready. Drop state sinks beats freely.
  assign s_ready = aresetn && ((state_q == StDrop) || !(out_vld_q && skid_vld_q));
  assign accept  = s_axis.tvalid && s_ready;
  assign pop     = out_vld_q && m_axis.tready;

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    push       = 1'b0;
    push_dest  = dest_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (head_ok) begin
            push      = 1'b1;
            push_dest = head_dest;
            dest_d    = head_dest;
            if (s_axis.tlast) pkt_cnt_d = pkt_cnt_q + 16'd1;
            else              state_d   = StFwd;
          end else begin
            drop_cnt_d = drop_cnt_q + 16'd1;
            if (!s_axis.tlast) state_d = StDrop;
          end
        end
        StFwd: begin
          push = 1'b1;
          if (s_axis.tlast) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            state_d   = StIdle;
          end
        end
        StDrop: begin
          if (s_axis.tlast) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign push_beat = '{data: s_axis.tdata, keep: s_axis.tkeep, last: s_axis.tlast,
                       dest: push_dest};

  // Skid buffer: out_q feeds m_axis, skid_q only fills while out_q is stalled.
  // out_q is rewritten only when a new beat loads, so it holds its last value when empty.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = push;
        if (push) skid_d = push_beat;
      end else begin
        out_vld_d = push;
        if (push) out_d = push_beat;
      end
    end else if (push) begin
      skid_d     = push_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      dest_q     <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Outputs are forced to zero for as long as reset is held, not just after the reset edge.
  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = aresetn && out_vld_q;
  assign m_axis.tdata  = aresetn ? out_q.data : '0;
  assign m_axis.tkeep  = aresetn ? out_q.keep : '0;
  assign m_axis.tlast  = aresetn && out_q.last;
  assign m_axis.tdest  = aresetn ? out_q.dest : '0;

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
  assign busy          = aresetn && ((state_q != StIdle) || out_vld_q || skid_vld_q);

endmodule

// File: tb/tb_axis_io_route_stage.sv
module tb_axis_io_route_stage;
  localparam int unsigned DataBits = 32;
  localparam int unsigned DestBits = 2;
  localparam int unsigned NDest    = 4;

  logic        clk;
  logic        rstn;
  logic [7:0]  io_ctrl;
  logic [15:0] stat_pkt_cnt;
  logic [15:0] stat_drop_cnt;
  logic        busy;

  axis_io_route_stage_if #(.DATA_BITS(DataBits), .DEST_BITS(DestBits)) s_if ();
  axis_io_route_stage_if #(.DATA_BITS(DataBits), .DEST_BITS(DestBits)) m_if ();

  axis_io_route_stage #(
    .DATA_BITS(DataBits),
    .DEST_BITS(DestBits),
    .N_DEST   (NDest)
  ) dut (
    .aclk         (clk),
    .aresetn      (rstn),
    .io_ctrl      (io_ctrl),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_drop_cnt(stat_drop_cnt),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [38:0] m_beat;
  assign m_beat = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tdest};

  // Reference model: packet-level routing rules, queue of beats owed on m_axis.
  logic [38:0] exp_q[$];
  logic [38:0] last_beat;
  bit          at_head;
  bit          cur_fwd;
  int          cur_dest;
  logic [15:0] m_pkt;
  logic [15:0] m_drop;

  int n_pass;
  int n_total;
  int n_fail;
  bit acc_flag;
  bit bp_en;
  int stall_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept();
    int io;
    if (at_head) begin
      io       = int'(io_ctrl);
      cur_dest = io % 4;
      cur_fwd  = (io >= 128) && (cur_dest < int'(NDest));
      if (!cur_fwd) m_drop = m_drop + 16'd1;
    end
    if (cur_fwd) begin
      exp_q.push_back({s_if.tdata, s_if.tkeep, s_if.tlast, 2'(cur_dest)});
      if (s_if.tlast) m_pkt = m_pkt + 16'd1;
    end
    at_head = s_if.tlast;
  endtask

  // One clock: check outputs mid-cycle, advance the model, then drive m_axis ready.
  task automatic tick();
    bit exp_ready;
    @(negedge clk);
    acc_flag = 1'b0;
    if (!rstn) begin
      chk("rst_outputs", 64'({m_if.tvalid, s_if.tready, busy, m_beat}), 64'd0);
      exp_q.delete();
      at_head   = 1'b1;
      cur_fwd   = 1'b0;
      m_pkt     = '0;
      m_drop    = '0;
      last_beat = '0;
    end else begin
      exp_ready = (!at_head && !cur_fwd) || (exp_q.size() < 2);
      chk("s_tready", 64'(s_if.tready), 64'(exp_ready));
      chk("m_tvalid", 64'(m_if.tvalid), 64'(exp_q.size() > 0));
      chk("busy", 64'(busy), 64'(!at_head || exp_q.size() > 0));
      chk("pkt_cnt", 64'(stat_pkt_cnt), 64'(m_pkt));
      chk("drop_cnt", 64'(stat_drop_cnt), 64'(m_drop));
      if (exp_q.size() > 0) chk("m_beat", 64'(m_beat), 64'(exp_q[0]));
      else                  chk("m_hold", 64'(m_beat), 64'(last_beat));
      if (m_if.tvalid && m_if.tready && exp_q.size() > 0) last_beat = exp_q.pop_front();
      if (s_if.tvalid && s_if.tready) begin
        acc_flag = 1'b1;
        model_accept();
      end
    end
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      m_if.tready = 1'b0;
      stall_left--;
    end else begin
      m_if.tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic send_beat(input logic last);
    bit ok;
    s_if.tvalid = 1'b1;
    s_if.tdata  = $urandom;
    s_if.tkeep  = 4'($urandom);
    s_if.tlast  = last;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (acc_flag) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int gap, input bit scramble);
    for (int i = 0; i < len; i++) begin
      send_beat(i == len - 1);
      if (scramble) io_ctrl = 8'($urandom);
    end
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    s_if.tvalid = 1'b0;
    rstn = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rstn = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    at_head = 1'b1; cur_fwd = 1'b0; cur_dest = 0;
    m_pkt = '0; m_drop = '0; last_beat = '0;
    bp_en = 1'b0; stall_left = 0;
    io_ctrl = 8'h00;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tdest = '0;
    m_if.tready = 1'b1;
    rstn = 1'b0;
    #1;
    do_reset(3);
    tick();

    // Forwarded 4-beat packet to dest 2.
    io_ctrl = 8'h82;
    send_pkt(4, 0, 1'b0);
    drain();
    chk("t1_pkt_cnt", 64'(stat_pkt_cnt), 64'd1);

    // Disabled route: dropped 3-beat packet.
    io_ctrl = 8'h03;
    send_pkt(3, 1, 1'b0);
    chk("t2_drop_cnt", 64'(stat_drop_cnt), 64'd1);

    // Route held across mid-packet io_ctrl change; next packet takes the new route.
    io_ctrl = 8'h81;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) io_ctrl = 8'h83;
      send_beat(i == 4);
    end
    send_pkt(2, 0, 1'b0);
    drain();
    chk("t3_pkt_cnt", 64'(stat_pkt_cnt), 64'd3);

    // Downstream stall of 5 cycles mid-packet.
    io_ctrl = 8'h82;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) stall_left = 5;
      send_beat(i == 7);
    end
    drain();

    // Reset mid-packet, then a fresh head.
    io_ctrl = 8'h81;
    send_beat(1'b0);
    send_beat(1'b0);
    do_reset(1);
    tick();
    chk("t5_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
    chk("t5_drop_cnt", 64'(stat_drop_cnt), 64'd0);
    io_ctrl = 8'h80;
    send_pkt(4, 0, 1'b0);
    drain();

    // Randomized traffic with backpressure and io_ctrl churn.
    bp_en = 1'b1;
    for (int p = 0; p < 250; p++) begin
      io_ctrl = 8'($urandom);
      if ($urandom_range(0, 3) != 0) io_ctrl[7] = 1'b1;
      send_pkt($urandom_range(1, 6), $urandom_range(0, 2), 1'b1);
    end
    bp_en = 1'b0;
    drain();

    // Forward counter wrap with single-beat packets.
    do_reset(1);
    io_ctrl = 8'h80;
    for (int p = 0; p < 65537; p++) send_beat(1'b1);
    drain();
    chk("t6_pkt_wrap", 64'(stat_pkt_cnt), 64'd1);
    chk("t6_drop_cnt", 64'(stat_drop_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
